// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the CPU fetch port, the loader/debug port and the
// instruction-memory port of imem_arbiter. The slave modport is the arbiter's
// view; the master modport is the view of the CPU, loader and memory around it.
`timescale 1ns/1ps
interface imem_arbiter_if #(
  parameter int AW = 8
);
  logic          cpu_req;
  logic [31:0]   cpu_pc;
  logic          cpu_ack;
  logic [31:0]   cpu_instr;
  logic          cpu_fault;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          ld_we;
  logic [31:0]   ld_wdata;
  logic          ld_ack;
  logic [31:0]   ld_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_pc,
    output cpu_ack, cpu_instr, cpu_fault,
    input  ld_req, ld_addr, ld_we, ld_wdata,
    output ld_ack, ld_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_pc,
    input  cpu_ack, cpu_instr, cpu_fault,
    output ld_req, ld_addr, ld_we, ld_wdata,
    input  ld_ack, ld_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory between a CPU fetch port and a
// loader/debug port. Loader has priority; after STARVE_LIMIT consecutive
// loader grants with the CPU waiting, the CPU is granted once. Each access is
// a grant cycle (IDLE) followed by one access cycle (ACC); the ack follows.
// Optional feature: define IMEM_ARB_FAULT_EN to flag misaligned or
// out-of-range CPU fetch addresses with cpu_fault instead of accessing memory.
`timescale 1ns/1ps
module imem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  imem_arbiter_if.slave  bus
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACC   = 1'b1;
  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_LD  = 1'b1;

  logic [0:0]    state_q,     state_d;
  logic [SW-1:0] starve_q,    starve_d;
  logic          cpu_ack_q,   cpu_ack_d;
  logic          ld_ack_q,    ld_ack_d;
  logic          cpu_fault_q, cpu_fault_d;
  logic [31:0]   cpu_instr_q, cpu_instr_d;
  logic [31:0]   ld_rdata_q,  ld_rdata_d;
  logic          owner_q,     owner_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic          we_q,        we_d;
  logic [31:0]   wdata_q,     wdata_d;
  logic          fault_q,     fault_d;

  logic pc_bad;
  logic starved;
  logic grant_cpu;
  logic grant_ld;

`ifdef IMEM_ARB_FAULT_EN
  assign pc_bad = (bus.cpu_pc[1:0] != 2'b00) || ((bus.cpu_pc >> (AW + 2)) != 32'd0);
  assign bus.cpu_fault = cpu_fault_q;
`else
  // Upper/lower PC bits are deliberately ignored in this build.
  logic unused_cfg;
  assign unused_cfg    = ^{bus.cpu_pc[31:AW+2], bus.cpu_pc[1:0], cpu_fault_q};
  assign pc_bad        = 1'b0;
  assign bus.cpu_fault = 1'b0;
`endif

  assign starved   = (starve_q == SW'(STARVE_LIMIT));
  assign grant_cpu = (state_q == S_IDLE) && bus.cpu_req && (!bus.ld_req || starved);
  assign grant_ld  = (state_q == S_IDLE) && bus.ld_req && !grant_cpu;

  // A faulted CPU fetch never drives its address onto the memory.
  assign bus.mem_addr  = ((state_q == S_ACC) && !((owner_q == OWN_CPU) && fault_q)) ? addr_q : '0;
  // Write enable is cut combinationally by reset so a reset mid-write is harmless.
  assign bus.mem_we    = reset_n && (state_q == S_ACC) && (owner_q == OWN_LD) && we_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.cpu_instr = cpu_instr_q;
  assign bus.ld_rdata  = ld_rdata_q;

  // Grant decision, starvation bookkeeping and completion capture.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    cpu_fault_d = 1'b0;
    cpu_instr_d = cpu_instr_q;
    ld_rdata_d  = ld_rdata_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    fault_d     = fault_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.cpu_req) starve_d = '0;
        if (grant_ld) begin
          state_d = S_ACC;
          owner_d = OWN_LD;
          addr_d  = bus.ld_addr;
          we_d    = bus.ld_we;
          wdata_d = bus.ld_wdata;
          fault_d = 1'b0;
          if (bus.cpu_req && !starved) starve_d = starve_q + 1'b1;
        end else if (grant_cpu) begin
          state_d  = S_ACC;
          owner_d  = OWN_CPU;
          addr_d   = bus.cpu_pc[AW+1:2];
          we_d     = 1'b0;
          fault_d  = pc_bad;
          starve_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (owner_q == OWN_LD) begin
          ld_ack_d   = 1'b1;
          ld_rdata_d = bus.mem_rdata;
        end else begin
          cpu_ack_d = 1'b1;
          if (fault_q) cpu_fault_d = 1'b1;
          else         cpu_instr_d = bus.mem_rdata;
        end
      end
    endcase
  end

  // Control and output registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_fault_q <= 1'b0;
      cpu_instr_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      cpu_fault_q <= cpu_fault_d;
      cpu_instr_q <= cpu_instr_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Access descriptor latched at grant; only meaningful while in ACC.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
    fault_q <= fault_d;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed bench for imem_arbiter with a transaction-level
// reference model (reference memory, starvation counter, one access in
// flight) checked every cycle, plus hand-computed literal expectations.
// Build with or without IMEM_ARB_FAULT_EN; expectations follow the macro.
`timescale 1ns/1ps
module tb_imem_arbiter;
  localparam int AW  = 8;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(AW)) bus ();
  imem_arbiter #(.STARVE_LIMIT(LIM), .AW(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // Instruction memory: combinational read, synchronous write.
  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:255];
  bit          m_valid = 1'b0;
  bit          m_busy, m_own_ld, m_we, m_fault;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  int          m_starve;
  logic        e_cpu_ack, e_ld_ack, e_fault;
  logic [31:0] e_instr, e_rdata;

  function automatic bit pc_illegal(input logic [31:0] pc);
`ifdef IMEM_ARB_FAULT_EN
    return (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid = 1'b1; m_busy = 1'b0; m_starve = 0;
      e_cpu_ack = 1'b0; e_ld_ack = 1'b0; e_fault = 1'b0;
      e_instr = '0; e_rdata = '0;
    end else if (m_valid) begin
      e_cpu_ack = 1'b0; e_ld_ack = 1'b0; e_fault = 1'b0;
      if (m_busy) begin
        m_busy = 1'b0;
        if (m_own_ld) begin
          e_ld_ack = 1'b1;
          e_rdata  = ref_mem[m_addr];
          if (m_we) ref_mem[m_addr] = m_wdata;
        end else begin
          e_cpu_ack = 1'b1;
          if (m_fault) e_fault = 1'b1;
          else         e_instr = ref_mem[m_addr];
        end
      end else if (bus.cpu_req && (!bus.ld_req || m_starve == LIM)) begin
        m_busy = 1'b1; m_own_ld = 1'b0; m_we = 1'b0;
        m_addr = bus.cpu_pc[AW+1:2]; m_fault = pc_illegal(bus.cpu_pc);
        m_starve = 0;
      end else if (bus.ld_req) begin
        m_busy = 1'b1; m_own_ld = 1'b1; m_we = bus.ld_we; m_fault = 1'b0;
        m_addr = bus.ld_addr; m_wdata = bus.ld_wdata;
        m_starve = bus.cpu_req ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
      end else begin
        m_starve = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cpu_ack",   32'(bus.cpu_ack),   32'(e_cpu_ack));
      check("ld_ack",    32'(bus.ld_ack),    32'(e_ld_ack));
      check("cpu_fault", 32'(bus.cpu_fault), 32'(e_fault));
      check("cpu_instr", bus.cpu_instr,      e_instr);
      check("ld_rdata",  bus.ld_rdata,       e_rdata);
      check("mem_we",    32'(bus.mem_we),    32'(reset_n && m_busy && m_own_ld && m_we));
      check("mem_addr",  32'(bus.mem_addr),
            (m_busy && !(!m_own_ld && m_fault)) ? 32'(m_addr) : 32'd0);
      check("ack_overlap", 32'(bus.cpu_ack & bus.ld_ack), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cpu_fetch(input logic [31:0] pc, output int lat, output bit saw_we);
    bus.cpu_pc = pc; bus.cpu_req = 1'b1; lat = 0; saw_we = 1'b0;
    do begin
      step(); lat++;
      if (bus.mem_we) saw_we = 1'b1;
    end while (!bus.cpu_ack && lat < 20);
    bus.cpu_req = 1'b0;
  endtask

  task automatic ld_xfer(input logic we, input logic [7:0] a, input logic [31:0] d, output int lat);
    bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d; bus.ld_req = 1'b1; lat = 0;
    do begin
      step(); lat++;
    end while (!bus.ld_ack && lat < 20);
    bus.ld_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit saw_we;
    logic [5:0] order;
    int n_acks;

    for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    mem[0]  = 32'hCAFEF00D; ref_mem[0]  = 32'hCAFEF00D;
    mem[2]  = 32'hDEADBEEF; ref_mem[2]  = 32'hDEADBEEF;
    mem[16] = 32'hA5A5A5A5; ref_mem[16] = 32'hA5A5A5A5;

    bus.cpu_req = 1'b0; bus.cpu_pc = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_we = 1'b0; bus.ld_wdata = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    check("rst_ld_ack",    32'(bus.ld_ack),    32'd0);
    check("rst_cpu_fault", 32'(bus.cpu_fault), 32'd0);
    check("rst_cpu_instr", bus.cpu_instr,      32'd0);
    check("rst_ld_rdata",  bus.ld_rdata,       32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    reset_n = 1'b1;
    step();

    // CPU fetch of word 2
    cpu_fetch(32'h0000_0008, lat, saw_we);
    check("fetch_latency", 32'(lat), 32'd2);
    check("fetch_instr",   bus.cpu_instr, 32'hDEADBEEF);
    step();

    // Loader write then read back
    ld_xfer(1'b1, 8'h05, 32'h12345678, lat);
    check("ldw_latency", 32'(lat), 32'd2);
    ld_xfer(1'b0, 8'h05, 32'h0, lat);
    check("ldr_latency", 32'(lat), 32'd2);
    check("ldr_data",    bus.ld_rdata, 32'h12345678);
    step();

    // Both requesting continuously: expect LD,LD,LD,LD,CPU,LD
    bus.cpu_pc = 32'h0000_0008; bus.ld_addr = 8'h05; bus.ld_we = 1'b0;
    bus.cpu_req = 1'b1; bus.ld_req = 1'b1;
    order = '0; n_acks = 0;
    for (int c = 0; c < 40 && n_acks < 6; c++) begin
      step();
      if (bus.cpu_ack || bus.ld_ack) begin
        order = {order[4:0], bus.cpu_ack};
        n_acks++;
      end
    end
    bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
    check("starve_acks",  32'(n_acks), 32'd6);
    check("starve_order", 32'(order),  32'(6'b000010));
    step();

    // Illegal-looking PC 0x402
    cpu_fetch(32'h0000_0402, lat, saw_we);
    check("pc402_latency", 32'(lat), 32'd2);
    check("pc402_no_we",   32'(saw_we), 32'd0);
`ifdef IMEM_ARB_FAULT_EN
    check("pc402_fault",   32'(bus.cpu_fault), 32'd1);
    check("pc402_instr",   bus.cpu_instr, 32'hDEADBEEF);
`else
    check("pc402_fault",   32'(bus.cpu_fault), 32'd0);
    check("pc402_instr",   bus.cpu_instr, 32'hCAFEF00D);
`endif
    step();

    // Reset during the ACC cycle of a loader write to 0x10
    bus.ld_we = 1'b1; bus.ld_addr = 8'h10; bus.ld_wdata = 32'h11111111; bus.ld_req = 1'b1;
    step();
    check("acc_mem_we_before_rst", 32'(bus.mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("acc_mem_we_in_rst", 32'(bus.mem_we), 32'd0);
    bus.ld_req = 1'b0;
    step();
    check("rst_acc_ld_ack",    32'(bus.ld_ack),    32'd0);
    check("rst_acc_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    check("rst_acc_cpu_instr", bus.cpu_instr,      32'd0);
    check("rst_acc_ld_rdata",  bus.ld_rdata,       32'd0);
    check("rst_acc_cpu_fault", 32'(bus.cpu_fault), 32'd0);
    check("rst_acc_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_acc_mem16",     mem[16],            32'hA5A5A5A5);
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_ld_ack", 32'(bus.ld_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
